tdc_measurement_sequencer: RTL and testbench

Controls one fine TDC channel and its thermometer-to-binary encoder.
- Re-arms the TDC by pulsing its reset.
- Counts coarse clock cycles from arm to hit.
- Waits the fixed encoder pipeline latency, then samples the fine code.
- Presents a {timeout, coarse, fine} timestamp on a valid/ready interface to the readout logic.

---
 rtl/tdc_seq_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/tdc_measurement_sequencer.sv | 129 ++++++++++++
 tb/tb_tdc_measurement_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_seq_pkg.sv
// Shared state encoding and default widths for the TDC measurement sequencer.
package tdc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REARM    = 3'd1,
    ARMED    = 3'd2,
    WAIT_ENC = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  localparam int DEF_FINE_BITS    = 8;
  localparam int DEF_COARSE_BITS  = 16;
  localparam int DEF_ENC_LATENCY  = 4;
  localparam int DEF_REARM_CYCLES = 3;

  // Down-counters run from cycles-1 to 0, so a count of N spans N cycles.
  function automatic logic [7:0] cnt_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; increments on inc, holds at all ones.
// Latency: count reflects an inc one cycle later; no backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tdc_measurement_sequencer.sv
// Arms one fine TDC, counts coarse cycles to the hit, samples the encoder after its
// pipeline delay; ts_valid rises hit+ENC_LATENCY+1 and holds the timestamp until ts_ready.
module tdc_measurement_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int FINE_BITS    = DEF_FINE_BITS,
  parameter int COARSE_BITS  = DEF_COARSE_BITS,
  parameter int ENC_LATENCY  = DEF_ENC_LATENCY,
  parameter int REARM_CYCLES = DEF_REARM_CYCLES,
  parameter bit CONTINUOUS   = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   hit_flag,
  input  logic [FINE_BITS-1:0]   value_fine,
  output logic                   tdc_reset,
  output logic                   busy,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [COARSE_BITS-1:0] ts_coarse,
  output logic [FINE_BITS-1:0]   ts_fine,
  output logic                   ts_timeout,
  output logic [7:0]             dropped_hits
);

  localparam logic [7:0]             REARM_LOAD = cnt_load(REARM_CYCLES);
  localparam logic [7:0]             LAT_LOAD   = cnt_load(ENC_LATENCY);
  localparam logic [COARSE_BITS-1:0] COARSE_MAX = '1;

  state_t                   state;
  state_t                   state_nxt;
  logic [7:0]               rearm_cnt;
  logic [7:0]               lat_cnt;
  logic [COARSE_BITS-1:0]   coarse;
  logic                     rearm_done;
  logic                     lat_done;
  logic                     at_max;
  logic                     accept;

  assign rearm_done = (rearm_cnt == 8'd0);
  assign lat_done   = (lat_cnt == 8'd0);
  assign at_max     = (coarse == COARSE_MAX);
  assign accept     = ts_valid && ts_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = REARM;
      REARM:    if (rearm_done) state_nxt = ARMED;
      // A hit on the terminal-count cycle is a real measurement, not a timeout.
      ARMED: begin
        if (hit_flag)    state_nxt = WAIT_ENC;
        else if (at_max) state_nxt = OUTPUT;
      end
      WAIT_ENC: if (lat_done) state_nxt = OUTPUT;
      OUTPUT:   if (accept) state_nxt = CONTINUOUS ? REARM : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tdc_reset = reset || (state == REARM);
    busy      = (state != IDLE);
    ts_valid  = (state == OUTPUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rearm_cnt  <= 8'd0;
      lat_cnt    <= 8'd0;
      coarse     <= '0;
      ts_coarse  <= '0;
      ts_fine    <= '0;
      ts_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) rearm_cnt <= REARM_LOAD;
        end
        REARM: begin
          rearm_cnt <= rearm_cnt - 8'd1;
          coarse    <= '0;
        end
        ARMED: begin
          // Stop at terminal count; the window closes through the timeout path.
          if (!at_max) coarse <= coarse + 1'b1;
          if (hit_flag) begin
            ts_coarse  <= coarse;
            lat_cnt    <= LAT_LOAD;
            ts_timeout <= 1'b0;
          end else if (at_max) begin
            ts_coarse  <= COARSE_MAX;
            ts_fine    <= '0;
            ts_timeout <= 1'b1;
          end
        end
        WAIT_ENC: begin
          lat_cnt <= lat_cnt - 8'd1;
          if (lat_done) ts_fine <= value_fine;
        end
        OUTPUT: begin
          if (accept && CONTINUOUS) rearm_cnt <= REARM_LOAD;
        end
        default: begin
          rearm_cnt <= 8'd0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (8)
  ) u_dropped (
    .clock (clock),
    .reset (reset),
    .inc   (hit_flag && (state != ARMED)),
    .count (dropped_hits)
  );

endmodule

// File: tb/tb_tdc_measurement_sequencer.sv
// Bench for tdc_measurement_sequencer: default, 4-bit-coarse and continuous instances,
// a per-cycle vector table, corner-case sequences and a random run against a timeline model.
module tb_tdc_measurement_sequencer;

  localparam int REARM = 3;
  localparam int LAT   = 4;
  localparam int MAXC  = 15;
  localparam int INF   = 1 << 30;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: defaults
  logic        rst_a, start_a, hit_a, ready_a, tdcr_a, busy_a, valid_a, to_a;
  logic [7:0]  fine_a, tsfine_a, drop_a;
  logic [15:0] coarse_a;
  // Instance B: 4-bit coarse window
  logic        rst_b, start_b, hit_b, ready_b, tdcr_b, busy_b, valid_b, to_b;
  logic [7:0]  fine_b, tsfine_b, drop_b;
  logic [3:0]  coarse_b;
  // Instance C: continuous re-arm
  logic        rst_c, start_c, hit_c, ready_c, tdcr_c, busy_c, valid_c, to_c;
  logic [7:0]  fine_c, tsfine_c, drop_c;
  logic [15:0] coarse_c;

  tdc_measurement_sequencer dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .hit_flag(hit_a), .value_fine(fine_a),
    .tdc_reset(tdcr_a), .busy(busy_a), .ts_valid(valid_a), .ts_ready(ready_a),
    .ts_coarse(coarse_a), .ts_fine(tsfine_a), .ts_timeout(to_a), .dropped_hits(drop_a)
  );

  tdc_measurement_sequencer #(.COARSE_BITS(4)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .hit_flag(hit_b), .value_fine(fine_b),
    .tdc_reset(tdcr_b), .busy(busy_b), .ts_valid(valid_b), .ts_ready(ready_b),
    .ts_coarse(coarse_b), .ts_fine(tsfine_b), .ts_timeout(to_b), .dropped_hits(drop_b)
  );

  tdc_measurement_sequencer #(.CONTINUOUS(1'b1)) dut_c (
    .clock(clock), .reset(rst_c), .start(start_c), .hit_flag(hit_c), .value_fine(fine_c),
    .tdc_reset(tdcr_c), .busy(busy_c), .ts_valid(valid_c), .ts_ready(ready_c),
    .ts_coarse(coarse_c), .ts_fine(tsfine_c), .ts_timeout(to_c), .dropped_hits(drop_c)
  );

  typedef struct {
    logic        start;
    logic        hit;
    logic [7:0]  fine;
    logic        ready;
    logic        e_tdcr;
    logic        e_busy;
    logic        e_valid;
    logic [15:0] e_coarse;
    logic [7:0]  e_fine;
    logic        e_to;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic s, input logic h, input logic [7:0] f, input logic r,
                              input logic et, input logic eb, input logic ev,
                              input logic [15:0] ec, input logic [7:0] ef, input logic eto);
    vec_t v;
    v.start = s;  v.hit = h;  v.fine = f;  v.ready = r;
    v.e_tdcr = et; v.e_busy = eb; v.e_valid = ev;
    v.e_coarse = ec; v.e_fine = ef; v.e_to = eto;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int  act, t_arm, t_val, t_hit, m_drops;
    logic [3:0] m_coarse;
    logic [7:0] m_fine;
    logic m_to, in_rearm, armed, valid_m;

    // Default measurement: start c0, rearm c1-3, hit on the 10th ARMED cycle (c13).
    tbl[0] = mk(1, 0, 8'h11, 0, 0, 0, 0, 16'd0, 8'h00, 0);
    for (int i = 1; i <= 3; i++)  tbl[i] = mk(0, 0, 8'h11, 0, 1, 1, 0, 16'd0, 8'h00, 0);
    for (int i = 4; i <= 12; i++) tbl[i] = mk(0, 0, 8'h11, 0, 0, 1, 0, 16'd0, 8'h00, 0);
    tbl[13] = mk(0, 1, 8'h11, 0, 0, 1, 0, 16'd0, 8'h00, 0);
    for (int i = 14; i <= 16; i++) tbl[i] = mk(0, 0, 8'h11, 0, 0, 1, 0, 16'd0, 8'h00, 0);
    tbl[17] = mk(0, 0, 8'h5A, 0, 0, 1, 0, 16'd0, 8'h00, 0);
    tbl[18] = mk(0, 0, 8'h11, 0, 0, 1, 1, 16'd9, 8'h5A, 0);
    tbl[19] = mk(0, 0, 8'h11, 1, 0, 1, 1, 16'd9, 8'h5A, 0);
    tbl[20] = mk(0, 0, 8'h11, 0, 0, 0, 0, 16'd0, 8'h00, 0);

    {start_a, hit_a, ready_a, fine_a} = '0;
    {start_b, hit_b, ready_b, fine_b} = '0;
    {start_c, hit_c, ready_c, fine_c} = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) next_cycle();

    @(negedge clock);
    chk("rst.tdc_reset", tdcr_a, 1);
    chk("rst.busy", busy_a, 0);
    chk("rst.ts_valid", valid_a, 0);
    chk("rst.ts_coarse", coarse_a, 0);
    chk("rst.ts_fine", tsfine_a, 0);
    chk("rst.ts_timeout", to_a, 0);
    chk("rst.dropped", drop_a, 0);
    chk("rst.tdc_reset_b", tdcr_b, 1);
    next_cycle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int i = 0; i < 21; i++) begin
      start_a = tbl[i].start; hit_a = tbl[i].hit; fine_a = tbl[i].fine; ready_a = tbl[i].ready;
      @(negedge clock);
      chk($sformatf("tbl%0d.tdc_reset", i), tdcr_a, tbl[i].e_tdcr);
      chk($sformatf("tbl%0d.busy", i), busy_a, tbl[i].e_busy);
      chk($sformatf("tbl%0d.ts_valid", i), valid_a, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d.ts_coarse", i), coarse_a, tbl[i].e_coarse);
        chk($sformatf("tbl%0d.ts_fine", i), tsfine_a, tbl[i].e_fine);
        chk($sformatf("tbl%0d.ts_timeout", i), to_a, tbl[i].e_to);
      end
      next_cycle();
    end
    chk("tbl.dropped", drop_a, 0);

    // Hold in OUTPUT for 20 cycles with a stray start and two stray hits.
    for (int c = 0; c <= 30; c++) begin
      start_a = (c == 0) || (c == 12);
      hit_a   = (c == 4) || (c == 15) || (c == 20);
      fine_a  = (c == 8) ? 8'hA7 : 8'($urandom);
      ready_a = (c >= 29);
      @(negedge clock);
      if (c >= 9 && c <= 29) begin
        chk($sformatf("hold%0d.ts_valid", c), valid_a, 1);
        chk($sformatf("hold%0d.ts_coarse", c), coarse_a, 0);
        chk($sformatf("hold%0d.ts_fine", c), tsfine_a, 8'hA7);
        chk($sformatf("hold%0d.ts_timeout", c), to_a, 0);
      end else begin
        chk($sformatf("hold%0d.ts_valid", c), valid_a, 0);
      end
      if (c == 30) begin
        chk("hold.busy_after", busy_a, 0);
        chk("hold.dropped", drop_a, 2);
      end
      next_cycle();
    end

    // Reset during WAIT_ENC; a hit on the release cycle is counted as dropped.
    for (int c = 0; c <= 20; c++) begin
      start_a = (c == 0);
      hit_a   = (c == 6) || (c == 11);
      fine_a  = 8'h3C;
      ready_a = 1'b1;
      rst_a   = (c >= 8) && (c <= 10);
      @(negedge clock);
      if (c == 7) chk("rstmid.busy_wait", busy_a, 1);
      if (c >= 8 && c <= 10) chk($sformatf("rstmid%0d.tdc_reset", c), tdcr_a, 1);
      if (c == 9) begin
        chk("rstmid.busy", busy_a, 0);
        chk("rstmid.dropped_clr", drop_a, 0);
      end
      if (c >= 9) chk($sformatf("rstmid%0d.ts_valid", c), valid_a, 0);
      if (c == 11) chk("rstmid.tdc_reset_rel", tdcr_a, 0);
      if (c == 12) begin
        chk("rstmid.dropped_rel", drop_a, 1);
        chk("rstmid.busy_rel", busy_a, 0);
      end
      next_cycle();
    end
    rst_a = 1'b0; start_a = 1'b0; ready_a = 1'b0;

    // Stray hits in IDLE saturate the drop counter.
    for (int i = 0; i < 300; i++) begin
      hit_a = 1'b1;
      @(negedge clock);
      if (i == 100) chk("sat.mid", drop_a, 101);
      next_cycle();
    end
    hit_a = 1'b0;
    @(negedge clock);
    chk("sat.final", drop_a, 255);
    next_cycle();

    // 4-bit window: hit exactly on coarse 15 is a normal measurement.
    for (int c = 0; c <= 26; c++) begin
      start_b = (c == 0);
      hit_b   = (c == 19);
      fine_b  = (c == 23) ? 8'h9C : 8'h55;
      ready_b = (c == 24);
      @(negedge clock);
      if (c == 19) chk("hit15.busy", busy_b, 1);
      if (c == 20 || c == 23) chk($sformatf("hit15_%0d.ts_valid", c), valid_b, 0);
      if (c == 24) begin
        chk("hit15.ts_valid", valid_b, 1);
        chk("hit15.ts_coarse", coarse_b, 4'hF);
        chk("hit15.ts_fine", tsfine_b, 8'h9C);
        chk("hit15.ts_timeout", to_b, 0);
      end
      if (c == 25) begin
        chk("hit15.valid_drop", valid_b, 0);
        chk("hit15.busy_after", busy_b, 0);
      end
      next_cycle();
    end

    // 4-bit window with no hit: timeout after 16 ARMED cycles.
    for (int c = 0; c <= 22; c++) begin
      start_b = (c == 0);
      hit_b   = 1'b0;
      fine_b  = 8'h77;
      ready_b = (c == 20);
      @(negedge clock);
      if (c >= 1 && c <= 3) chk($sformatf("tmo%0d.tdc_reset", c), tdcr_b, 1);
      if (c == 19) begin
        chk("tmo.valid_early", valid_b, 0);
        chk("tmo.tdc_reset_armed", tdcr_b, 0);
      end
      if (c == 20) begin
        chk("tmo.ts_valid", valid_b, 1);
        chk("tmo.ts_coarse", coarse_b, 4'hF);
        chk("tmo.ts_fine", tsfine_b, 0);
        chk("tmo.ts_timeout", to_b, 1);
      end
      if (c == 21) chk("tmo.busy_after", busy_b, 0);
      next_cycle();
    end
    start_b = 1'b0; ready_b = 1'b0;

    // Continuous mode: accepted timestamp re-arms without a new start.
    for (int c = 0; c <= 26; c++) begin
      start_c = (c == 0);
      hit_c   = (c == 8) || (c == 19);
      fine_c  = (c == 12) ? 8'hC3 : ((c == 23) ? 8'h33 : 8'h00);
      ready_c = 1'b1;
      @(negedge clock);
      chk($sformatf("cont%0d.tdc_reset", c), tdcr_c,
          ((c >= 1 && c <= 3) || (c >= 14 && c <= 16) || c >= 25) ? 1 : 0);
      chk($sformatf("cont%0d.ts_valid", c), valid_c, (c == 13 || c == 24) ? 1 : 0);
      if (c == 13) begin
        chk("cont1.ts_coarse", coarse_c, 4);
        chk("cont1.ts_fine", tsfine_c, 8'hC3);
        chk("cont1.ts_timeout", to_c, 0);
      end
      if (c == 24) begin
        chk("cont2.ts_coarse", coarse_c, 2);
        chk("cont2.ts_fine", tsfine_c, 8'h33);
        chk("cont2.ts_timeout", to_c, 0);
      end
      if (c == 25) chk("cont.busy_rearm", busy_c, 1);
      next_cycle();
    end
    start_c = 1'b0; hit_c = 1'b0;

    // Random traffic on the 4-bit instance against a timeline model.
    act = 0; t_arm = 0; t_val = INF; t_hit = -1; m_drops = 0;
    m_coarse = '0; m_fine = '0; m_to = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      start_b = ($urandom_range(15) == 0);
      hit_b   = ($urandom_range(9) == 0);
      fine_b  = 8'($urandom);
      ready_b = 1'($urandom_range(1));
      @(negedge clock);
      in_rearm = (act != 0) && (n < t_arm);
      valid_m  = (act != 0) && (n >= t_val);
      armed    = (act != 0) && (n >= t_arm) && (t_hit < 0) && (t_val == INF);
      chk($sformatf("rnd%0d.tdc_reset", n), tdcr_b, in_rearm);
      chk($sformatf("rnd%0d.busy", n), busy_b, (act != 0));
      chk($sformatf("rnd%0d.ts_valid", n), valid_b, valid_m);
      chk($sformatf("rnd%0d.dropped", n), drop_b, m_drops);
      if (valid_m) begin
        chk($sformatf("rnd%0d.ts_coarse", n), coarse_b, m_coarse);
        chk($sformatf("rnd%0d.ts_fine", n), tsfine_b, m_fine);
        chk($sformatf("rnd%0d.ts_timeout", n), to_b, m_to);
      end
      if (act == 0 && start_b) begin
        act = 1; t_arm = n + 1 + REARM; t_val = INF; t_hit = -1;
      end else if (armed) begin
        if (hit_b) begin
          t_hit = n; t_val = n + LAT + 1; m_coarse = 4'(n - t_arm); m_to = 1'b0;
        end else if (n - t_arm == MAXC) begin
          t_val = n + 1; m_coarse = 4'hF; m_fine = 8'h00; m_to = 1'b1;
        end
      end
      if (t_hit >= 0 && n == t_hit + LAT) m_fine = fine_b;
      if (hit_b && !armed && m_drops < 255) m_drops++;
      if (valid_m && ready_b) act = 0;
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
